bcd_counter_n: RTL and testbench
================================

// Module: bcd_counter_n
// PURPOSE
//   Multi-digit synchronous BCD up/down counter, N_DIGITS packed 4-bit digits.
//   Successor to the single-digit combinational incrementor: adds registered state,
//   decrement, parallel load with digit validation, clear, and wrap/saturate modes.
//   Feeds BCD display/stopwatch datapaths; carry/borrow pulses cascade to further stages.
// PARAMETERS
//   N_DIGITS  4  number of BCD digits (1..8); count width = 4*N_DIGITS
//   SATURATE  0  0: wrap 99..9<->00..0; 1: hold at 99..9 / 00..0
// PORTS
//   clk        in   1           rising-edge clock
//   reset_n    in   1           synchronous reset, active-low
//   clr        in   1           synchronous clear to 0
//   load       in   1           parallel load strobe
//   load_val   in   4*N_DIGITS  BCD value to load, digit 0 in [3:0]
//   inc        in   1           count up by 1
//   dec        in   1           count down by 1
//   count      out  4*N_DIGITS  registered BCD count, digit 0 in [3:0]
//   carry      out  1           registered 1-cycle pulse: up-overflow
//   borrow     out  1           registered 1-cycle pulse: down-underflow
//   load_err   out  1           registered 1-cycle pulse: load rejected
//   at_max     out  1           comb: count == all digits 9
//   at_zero    out  1           comb: count == 0
// BEHAVIOUR
//   - Reset (reset_n=0 at edge): count=0, carry=borrow=load_err=0; overrides all inputs.
//   - Priority per edge: reset_n > clr > load > (inc xor dec). inc&dec both 1 = no-op.
//   - carry/borrow/load_err are 0 on every edge except where set below (pulse, not level).
//   - clr: count<=0. No pulses.
//   - load: if every digit of load_val <= 9, count<=load_val; else count unchanged,
//     load_err<=1. Any digit 10..15 rejects the whole word (no partial load).
//   - inc: digit k increments; digit k wraps 9->0 and ripples +1 into k+1 when all
//     lower digits were 9. Latency: new count visible 1 cycle after strobe edge.
//   - dec: digit k wraps 0->9 and ripples borrow into k+1 when all lower digits were 0.
//   - Overflow (inc at at_max): SATURATE=0 -> count<=0, carry<=1.
//     SATURATE=1 -> count held at all-9, carry<=1 (flags attempted overflow).
//   - Underflow (dec at at_zero): SATURATE=0 -> count<=all-9, borrow<=1.
//     SATURATE=1 -> count held at 0, borrow<=1.
//   - carry/borrow never asserted together; carry never asserted without inc.
//   - Count register never holds a digit >9 under any input sequence.
//   - Ripple logic is combinational across all digits in one cycle (no per-digit
//     pipelining); continuous inc=1 counts one step per clock.
//   - Reset asserted mid-count: next edge count=0, pending pulses cleared.
// TESTING  (N_DIGITS=4 unless noted)
//   1 reset_n=0 one edge with inc=1, load=1 -> count=0000, carry=borrow=load_err=0.
//   2 load 0x0998, inc x3 -> 0999, 1000, 1001; carry stays 0; at_max never 1.
//   3 SATURATE=0: load 9999, inc -> 0000, carry=1 one cycle; dec -> 9999, borrow=1.
//   4 SATURATE=1: load 9999, inc x2 -> 9999 held, carry=1 each cycle; clr -> 0000,
//     dec -> 0000 held, borrow=1.
//   5 count=0123, load 0x12A4 -> count stays 0123, load_err=1 one cycle; inc&dec=1 ->
//     0123 unchanged; clr&load(0x0555) same edge -> 0000.
//   6 Exhaustive: N_DIGITS=2, inc 100x from 00 -> every step +1 decimal, carry only at
//     99->00; then dec 100x -> mirrors, borrow only at 00->99; no digit >9 ever.

Source files
------------

// File: rtl/bcd_counter_n_if.sv
// Control/status bundle for the multi-digit BCD counter.
// The master drives the strobes and load word; the slave returns count and flags.
interface bcd_counter_n_if #(
  parameter int N_DIGITS = 4
);
  logic                    clr;
  logic                    load;
  logic [4*N_DIGITS-1:0]   load_val;
  logic                    inc;
  logic                    dec;
  logic [4*N_DIGITS-1:0]   count;
  logic                    carry;
  logic                    borrow;
  logic                    load_err;
  logic                    at_max;
  logic                    at_zero;

  modport master (
    output clr, load, load_val, inc, dec,
    input  count, carry, borrow, load_err, at_max, at_zero
  );

  modport slave (
    input  clr, load, load_val, inc, dec,
    output count, carry, borrow, load_err, at_max, at_zero
  );
endinterface

// File: rtl/bcd_counter_n.sv
// Multi-digit synchronous BCD up/down counter with validated parallel load,
// clear, wrap/saturate overflow handling and one-cycle carry/borrow/load_err pulses.
module bcd_counter_n #(
  parameter int N_DIGITS = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  bcd_counter_n_if.slave    bus
);
  localparam int W = 4 * N_DIGITS;

  logic [W-1:0]          count_reg;
  logic                  carry_reg;
  logic                  borrow_reg;
  logic                  load_err_reg;

  // lo9[k]/lo0[k]: every digit below k is 9 / 0, i.e. digit k receives the ripple.
  logic [N_DIGITS:0]     lo9;
  logic [N_DIGITS:0]     lo0;
  logic [W-1:0]          inc_val;
  logic [W-1:0]          dec_val;
  logic [N_DIGITS-1:0]   digit_ok;

  assign lo9[0] = 1'b1;
  assign lo0[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      logic [3:0] digit;
      logic [3:0] ld_digit;
      assign digit    = count_reg[4*gi +: 4];
      assign ld_digit = bus.load_val[4*gi +: 4];

      assign lo9[gi+1] = lo9[gi] & (digit == 4'd9);
      assign lo0[gi+1] = lo0[gi] & (digit == 4'd0);

      assign inc_val[4*gi +: 4] = !lo9[gi]        ? digit :
                                  (digit == 4'd9) ? 4'd0  : digit + 4'd1;
      assign dec_val[4*gi +: 4] = !lo0[gi]        ? digit :
                                  (digit == 4'd0) ? 4'd9  : digit - 4'd1;

      assign digit_ok[gi] = (ld_digit <= 4'd9);
    end
  endgenerate

  assign bus.at_max  = lo9[N_DIGITS];
  assign bus.at_zero = lo0[N_DIGITS];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_reg    <= '0;
      carry_reg    <= 1'b0;
      borrow_reg   <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      carry_reg    <= 1'b0;
      borrow_reg   <= 1'b0;
      load_err_reg <= 1'b0;
      if (bus.clr) begin
        count_reg <= '0;
      end else if (bus.load) begin
        // Any out-of-range digit rejects the whole word.
        if (&digit_ok) count_reg    <= bus.load_val;
        else           load_err_reg <= 1'b1;
      end else if (bus.inc && !bus.dec) begin
        if (lo9[N_DIGITS]) begin
          carry_reg <= 1'b1;
          if (!SATURATE) count_reg <= inc_val;
        end else begin
          count_reg <= inc_val;
        end
      end else if (bus.dec && !bus.inc) begin
        if (lo0[N_DIGITS]) begin
          borrow_reg <= 1'b1;
          if (!SATURATE) count_reg <= dec_val;
        end else begin
          count_reg <= dec_val;
        end
      end
    end
  end

  assign bus.count    = count_reg;
  assign bus.carry    = carry_reg;
  assign bus.borrow   = borrow_reg;
  assign bus.load_err = load_err_reg;
endmodule

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n: three instances (4-digit wrap, 4-digit saturate,
// 2-digit wrap) checked every cycle against a decimal-integer model.
module tb_bcd_counter_n;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // Per-instance stimulus: 0 = N4 wrap, 1 = N4 saturate, 2 = N2 wrap.
  logic        clr_s [3];
  logic        load_s[3];
  logic        inc_s [3];
  logic        dec_s [3];
  logic [31:0] lv_s  [3];

  logic [31:0] cnt_o [3];
  logic        car_o [3];
  logic        bor_o [3];
  logic        lerr_o[3];
  logic        amax_o[3];
  logic        azero_o[3];

  bcd_counter_n_if #(.N_DIGITS(4)) if_a ();
  bcd_counter_n_if #(.N_DIGITS(4)) if_b ();
  bcd_counter_n_if #(.N_DIGITS(2)) if_c ();

  bcd_counter_n #(.N_DIGITS(4), .SATURATE(1'b0)) dut_a (.clk(clk), .reset_n(reset_n), .bus(if_a));
  bcd_counter_n #(.N_DIGITS(4), .SATURATE(1'b1)) dut_b (.clk(clk), .reset_n(reset_n), .bus(if_b));
  bcd_counter_n #(.N_DIGITS(2), .SATURATE(1'b0)) dut_c (.clk(clk), .reset_n(reset_n), .bus(if_c));

  assign if_a.clr = clr_s[0]; assign if_a.load = load_s[0]; assign if_a.inc = inc_s[0];
  assign if_a.dec = dec_s[0]; assign if_a.load_val = lv_s[0][15:0];
  assign if_b.clr = clr_s[1]; assign if_b.load = load_s[1]; assign if_b.inc = inc_s[1];
  assign if_b.dec = dec_s[1]; assign if_b.load_val = lv_s[1][15:0];
  assign if_c.clr = clr_s[2]; assign if_c.load = load_s[2]; assign if_c.inc = inc_s[2];
  assign if_c.dec = dec_s[2]; assign if_c.load_val = lv_s[2][7:0];

  assign cnt_o[0] = {16'd0, if_a.count};
  assign cnt_o[1] = {16'd0, if_b.count};
  assign cnt_o[2] = {24'd0, if_c.count};
  assign car_o[0] = if_a.carry;    assign car_o[1] = if_b.carry;    assign car_o[2] = if_c.carry;
  assign bor_o[0] = if_a.borrow;   assign bor_o[1] = if_b.borrow;   assign bor_o[2] = if_c.borrow;
  assign lerr_o[0] = if_a.load_err; assign lerr_o[1] = if_b.load_err; assign lerr_o[2] = if_c.load_err;
  assign amax_o[0] = if_a.at_max;  assign amax_o[1] = if_b.at_max;  assign amax_o[2] = if_c.at_max;
  assign azero_o[0] = if_a.at_zero; assign azero_o[1] = if_b.at_zero; assign azero_o[2] = if_c.at_zero;

  int total = 0;
  int bad   = 0;

  function automatic int ndig(int i);
    return (i == 2) ? 2 : 4;
  endfunction

  function automatic bit sat(int i);
    return (i == 1);
  endfunction

  function automatic int max_val(int i);
    return (i == 2) ? 99 : 9999;
  endfunction

  function automatic logic [31:0] to_bcd(int v);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // ---------------- behavioural model: count held as a plain integer ----------------
  int m_val [3];
  bit m_car [3];
  bit m_bor [3];
  bit m_lerr[3];
  bit started = 1'b0;

  always @(posedge clk) begin
    started <= 1'b1;
    for (int i = 0; i < 3; i++) begin
      automatic int  v    = m_val[i];
      automatic bit  c    = 1'b0;
      automatic bit  b    = 1'b0;
      automatic bit  le   = 1'b0;
      automatic bit  ok   = 1'b1;
      automatic int  lv   = 0;
      automatic int  w    = 1;
      if (!reset_n) begin
        v = 0;
      end else if (clr_s[i]) begin
        v = 0;
      end else if (load_s[i]) begin
        for (int k = 0; k < ndig(i); k++) begin
          if (lv_s[i][4*k +: 4] > 4'd9) ok = 1'b0;
          lv = lv + int'(lv_s[i][4*k +: 4]) * w;
          w  = w * 10;
        end
        if (ok) v = lv;
        else    le = 1'b1;
      end else if (inc_s[i] && !dec_s[i]) begin
        if (v == max_val(i)) begin
          c = 1'b1;
          v = sat(i) ? max_val(i) : 0;
        end else v = v + 1;
      end else if (dec_s[i] && !inc_s[i]) begin
        if (v == 0) begin
          b = 1'b1;
          v = sat(i) ? 0 : max_val(i);
        end else v = v - 1;
      end
      m_val[i]  <= v;
      m_car[i]  <= c;
      m_bor[i]  <= b;
      m_lerr[i] <= le;
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  task automatic cmp(string name, int i, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s[%0d] t=%0t got=%h exp=%h", name, i, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        automatic bit range_ok = 1'b1;
        for (int k = 0; k < ndig(i); k++)
          if (cnt_o[i][4*k +: 4] > 4'd9) range_ok = 1'b0;
        cmp("count",    i, cnt_o[i], to_bcd(m_val[i]));
        cmp("carry",    i, 32'(car_o[i]),   32'(m_car[i]));
        cmp("borrow",   i, 32'(bor_o[i]),   32'(m_bor[i]));
        cmp("load_err", i, 32'(lerr_o[i]),  32'(m_lerr[i]));
        cmp("at_max",   i, 32'(amax_o[i]),  32'(m_val[i] == max_val(i)));
        cmp("at_zero",  i, 32'(azero_o[i]), 32'(m_val[i] == 0));
        cmp("digit_ok", i, 32'(range_ok),   32'd1);
      end
    end
  end

  // ---------------- directed stimulus with literal pins ----------------
  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      clr_s[i] = 1'b0; load_s[i] = 1'b0; inc_s[i] = 1'b0; dec_s[i] = 1'b0; lv_s[i] = '0;
    end
  endtask

  task automatic drive(int i, bit c, bit l, logic [31:0] v, bit up, bit dn);
    idle_all();
    clr_s[i] = c; load_s[i] = l; lv_s[i] = v; inc_s[i] = up; dec_s[i] = dn;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL lit_%s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  initial begin
    // 1: reset dominates inc and load on every instance
    for (int i = 0; i < 3; i++) begin
      clr_s[i] = 1'b0; load_s[i] = 1'b1; inc_s[i] = 1'b1; dec_s[i] = 1'b0; lv_s[i] = 32'h0000_1234;
    end
    reset_n = 1'b0;
    tick();
    lit("reset_count", cnt_o[0], 32'h0);
    lit("reset_carry", 32'(car_o[0]), 32'h0);
    lit("reset_lerr",  32'(lerr_o[1]), 32'h0);
    $display("txn reset: count=%h", cnt_o[0]);
    reset_n = 1'b1;
    idle_all();
    tick();

    // 2: ripple across several digits
    drive(0, 0, 1, 32'h0998, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 0); tick(); lit("inc_0999", cnt_o[0], 32'h0999);
    $display("txn inc: count=%h", cnt_o[0]);
    tick(); lit("inc_1000", cnt_o[0], 32'h1000);
    $display("txn inc: count=%h", cnt_o[0]);
    tick(); lit("inc_1001", cnt_o[0], 32'h1001);
    lit("inc_no_carry", 32'(car_o[0]), 32'h0);
    $display("txn inc: count=%h", cnt_o[0]);

    // 3: wrap mode overflow/underflow
    drive(0, 0, 1, 32'h9999, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 0); tick();
    lit("wrap_ovf", cnt_o[0], 32'h0000); lit("wrap_carry", 32'(car_o[0]), 32'h1);
    $display("txn ovf: count=%h carry=%0b", cnt_o[0], car_o[0]);
    drive(0, 0, 0, 0, 0, 1); tick();
    lit("wrap_unf", cnt_o[0], 32'h9999); lit("wrap_borrow", 32'(bor_o[0]), 32'h1);
    lit("wrap_carry_gone", 32'(car_o[0]), 32'h0);
    $display("txn unf: count=%h borrow=%0b", cnt_o[0], bor_o[0]);

    // 4: saturate mode
    drive(1, 0, 1, 32'h9999, 0, 0); tick();
    drive(1, 0, 0, 0, 1, 0);
    for (int n = 0; n < 2; n++) begin
      tick();
      lit("sat_hold_max", cnt_o[1], 32'h9999); lit("sat_carry", 32'(car_o[1]), 32'h1);
      $display("txn sat inc: count=%h carry=%0b", cnt_o[1], car_o[1]);
    end
    drive(1, 1, 0, 0, 0, 0); tick(); lit("sat_clr", cnt_o[1], 32'h0);
    drive(1, 0, 0, 0, 0, 1); tick();
    lit("sat_hold_zero", cnt_o[1], 32'h0); lit("sat_borrow", 32'(bor_o[1]), 32'h1);
    $display("txn sat dec: count=%h borrow=%0b", cnt_o[1], bor_o[1]);

    // 5: rejected load, inc&dec no-op, clr beats load
    drive(0, 0, 1, 32'h0123, 0, 0); tick();
    drive(0, 0, 1, 32'h12A4, 0, 0); tick();
    lit("bad_load_hold", cnt_o[0], 32'h0123); lit("load_err", 32'(lerr_o[0]), 32'h1);
    $display("txn bad load: count=%h load_err=%0b", cnt_o[0], lerr_o[0]);
    drive(0, 0, 0, 0, 1, 1); tick();
    lit("incdec_noop", cnt_o[0], 32'h0123); lit("load_err_pulse", 32'(lerr_o[0]), 32'h0);
    drive(0, 1, 1, 32'h0555, 0, 0); tick();
    lit("clr_over_load", cnt_o[0], 32'h0);
    $display("txn clr+load: count=%h", cnt_o[0]);

    // reset mid-count clears a pending carry
    drive(2, 0, 1, 32'h99, 0, 0); tick();
    drive(2, 0, 0, 0, 1, 0); reset_n = 1'b0; tick();
    lit("mid_reset_count", cnt_o[2], 32'h0); lit("mid_reset_carry", 32'(car_o[2]), 32'h0);
    $display("txn mid reset: count=%h carry=%0b", cnt_o[2], car_o[2]);
    reset_n = 1'b1;

    // 6: exhaustive two-digit sweep up then down
    drive(2, 0, 0, 0, 1, 0);
    for (int n = 0; n < 100; n++) begin
      tick();
      $display("txn n2 inc %0d: count=%h carry=%0b", n, cnt_o[2], car_o[2]);
    end
    lit("n2_wrap", cnt_o[2], 32'h00); lit("n2_carry", 32'(car_o[2]), 32'h1);
    drive(2, 0, 0, 0, 0, 1);
    for (int n = 0; n < 100; n++) begin
      tick();
      if (n == 0) begin
        lit("n2_unf", cnt_o[2], 32'h99); lit("n2_borrow", 32'(bor_o[2]), 32'h1);
      end
      $display("txn n2 dec %0d: count=%h borrow=%0b", n, cnt_o[2], bor_o[2]);
    end
    lit("n2_end", cnt_o[2], 32'h00); lit("n2_at_zero", 32'(azero_o[2]), 32'h1);

    idle_all();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
